// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - four-wide register rename with speculative and committed maps
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall                    freezes rename and output registers
//   inst_valid, dst_valid    per-slot instruction / destination-write masks (slot 0 oldest)
//   src0_ar*, src1_ar*       per-slot source architectural registers
//   dst_ar*                  per-slot destination architectural registers
//   new_pr*                  physical registers offered by the free list, one per slot
//   list_empty               free list cannot supply registers this cycle
//   flush                    restore speculative map from committed map, drop group
//   commit_valid/ar*/pr*     retiring mappings written into the committed map
//   out_valid, *_pr*         registered rename results
//   rename_fire              group accepted this cycle (free list may advance)

module rename_map_table #(
    parameter int AR_W = 5,
    parameter int PR_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [3:0]      inst_valid,
    input  logic [3:0]      dst_valid,
    input  logic [AR_W-1:0] src0_ar0, src0_ar1, src0_ar2, src0_ar3,
    input  logic [AR_W-1:0] src1_ar0, src1_ar1, src1_ar2, src1_ar3,
    input  logic [AR_W-1:0] dst_ar0, dst_ar1, dst_ar2, dst_ar3,
    input  logic [PR_W-1:0] new_pr0, new_pr1, new_pr2, new_pr3,
    input  logic            list_empty,
    input  logic            flush,
    input  logic [3:0]      commit_valid,
    input  logic [AR_W-1:0] commit_ar0, commit_ar1, commit_ar2, commit_ar3,
    input  logic [PR_W-1:0] commit_pr0, commit_pr1, commit_pr2, commit_pr3,
    output logic [3:0]      out_valid,
    output logic [PR_W-1:0] src0_pr0, src0_pr1, src0_pr2, src0_pr3,
    output logic [PR_W-1:0] src1_pr0, src1_pr1, src1_pr2, src1_pr3,
    output logic [PR_W-1:0] dst_pr0, dst_pr1, dst_pr2, dst_pr3,
    output logic [PR_W-1:0] old_pr0, old_pr1, old_pr2, old_pr3,
    output logic            rename_fire
);
    localparam int NAR = 1 << AR_W;

    logic [PR_W-1:0] spec_map  [NAR];
    logic [PR_W-1:0] arch_map  [NAR];
    logic [PR_W-1:0] arch_next [NAR];

    logic [AR_W-1:0] s0_ar [4];
    logic [AR_W-1:0] s1_ar [4];
    logic [AR_W-1:0] d_ar  [4];
    logic [PR_W-1:0] n_pr  [4];
    logic [AR_W-1:0] c_ar  [4];
    logic [PR_W-1:0] c_pr  [4];

    logic [PR_W-1:0] s0_lk [4];
    logic [PR_W-1:0] s1_lk [4];
    logic [PR_W-1:0] d_lk  [4];
    logic [PR_W-1:0] o_lk  [4];

    logic [PR_W-1:0] s0_q [4];
    logic [PR_W-1:0] s1_q [4];
    logic [PR_W-1:0] d_q  [4];
    logic [PR_W-1:0] o_q  [4];

    assign s0_ar = '{src0_ar0, src0_ar1, src0_ar2, src0_ar3};
    assign s1_ar = '{src1_ar0, src1_ar1, src1_ar2, src1_ar3};
    assign d_ar  = '{dst_ar0, dst_ar1, dst_ar2, dst_ar3};
    assign n_pr  = '{new_pr0, new_pr1, new_pr2, new_pr3};
    assign c_ar  = '{commit_ar0, commit_ar1, commit_ar2, commit_ar3};
    assign c_pr  = '{commit_pr0, commit_pr1, commit_pr2, commit_pr3};

    assign rename_fire = (|inst_valid) & ~stall & ~list_empty & ~flush;

    // Lookup with intra-group bypass: scanning older slots in age order lets
    // the youngest matching writer overwrite earlier matches.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s0_lk[k] = spec_map[s0_ar[k]];
            s1_lk[k] = spec_map[s1_ar[k]];
            o_lk[k]  = spec_map[d_ar[k]];
            for (int j = 0; j < 4; j++) begin
                if (j < k && inst_valid[j] && dst_valid[j]) begin
                    if (d_ar[j] == s0_ar[k]) s0_lk[k] = n_pr[j];
                    if (d_ar[j] == s1_ar[k]) s1_lk[k] = n_pr[j];
                    if (d_ar[j] == d_ar[k])  o_lk[k]  = n_pr[j];
                end
            end
            if (!dst_valid[k]) o_lk[k] = '0;
            d_lk[k] = dst_valid[k] ? n_pr[k] : '0;
        end
    end

    // Committed map after this cycle's retirements; also the flush restore
    // source so a same-cycle commit is not lost.
    always_comb begin
        arch_next = arch_map;
        for (int k = 0; k < 4; k++) begin
            if (commit_valid[k]) arch_next[c_ar[k]] = c_pr[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NAR; i++) begin
                spec_map[i] <= PR_W'(i);
                arch_map[i] <= PR_W'(i);
            end
            out_valid <= '0;
            for (int k = 0; k < 4; k++) begin
                s0_q[k] <= '0;
                s1_q[k] <= '0;
                d_q[k]  <= '0;
                o_q[k]  <= '0;
            end
        end else begin
            arch_map <= arch_next;
            if (flush) begin
                spec_map  <= arch_next;
                out_valid <= '0;
            end else if (stall) begin
                out_valid <= out_valid;
            end else if (rename_fire) begin
                // Later slots are written last, so the youngest writer wins.
                for (int k = 0; k < 4; k++) begin
                    if (inst_valid[k] && dst_valid[k]) spec_map[d_ar[k]] <= n_pr[k];
                end
                out_valid <= inst_valid;
                s0_q <= s0_lk;
                s1_q <= s1_lk;
                d_q  <= d_lk;
                o_q  <= o_lk;
            end else begin
                out_valid <= '0;
            end
        end
    end

    assign {src0_pr0, src0_pr1, src0_pr2, src0_pr3} = {s0_q[0], s0_q[1], s0_q[2], s0_q[3]};
    assign {src1_pr0, src1_pr1, src1_pr2, src1_pr3} = {s1_q[0], s1_q[1], s1_q[2], s1_q[3]};
    assign {dst_pr0, dst_pr1, dst_pr2, dst_pr3}     = {d_q[0], d_q[1], d_q[2], d_q[3]};
    assign {old_pr0, old_pr1, old_pr2, old_pr3}     = {o_q[0], o_q[1], o_q[2], o_q[3]};

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Four-wide register rename stage for the allocation pipeline. It sits directly downstream of the free list: it consumes that block's four newly allocated physical registers and renames a group of up to four instructions per cycle. The block keeps a speculative map table (32 architectural to 64 physical registers) and a committed architectural map. On flush it restores the speculative map from the architectural map. It emits each instruction's renamed sources, its new destination, and the displaced old physical register, which commit later returns to the free list.

## Interface
- AR_W, 5, architectural register index width (32 entries)
- PR_W, 6, physical register index width (64 entries)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream stall; freezes rename and output registers
- inst_valid  in  4  bit k: slot k holds an instruction (slot 0 oldest)
- dst_valid  in  4  bit k: slot k writes a destination; same mask drives free list pr_need_inst_in
- src0_ar0..src0_ar3, src1_ar0..src1_ar3  in  AR_W each  source architectural registers per slot
- dst_ar0..dst_ar3  in  AR_W each  destination architectural register per slot
- new_pr0..new_pr3  in  PR_W each  free list pr_num_out0..3; new_prk belongs to slot k
- list_empty  in  1  free list cannot supply registers this cycle
- flush  in  1  squash all speculative state
- commit_valid  in  4  bit k: commit slot k retires a destination write
- commit_ar0..commit_ar3  in  AR_W each, commit_pr0..commit_pr3  in  PR_W each  retiring mapping
- out_valid  out  4  registered slot valid
- src0_pr0..3, src1_pr0..3, dst_pr0..3, old_pr0..3  out  PR_W each  registered rename results
- rename_fire  out  1  combinational; the current group is accepted this cycle

## Operation
- Reset: spec_map[i] = arch_map[i] = i for i in 0..31. out_valid = 0. All *_pr outputs = 0. Physical registers 32..63 belong to the free list.
- rename_fire = (|inst_valid) & ~stall & ~list_empty & ~flush.
- Source lookup for slot k: if an older slot j<k in the same group has inst_valid & dst_valid and dst_arj == src_ar, the result is new_prj, and the youngest such j wins. Otherwise the result is spec_map[src_ar].
- old_prk uses the same rule keyed on dst_ark. It is 0 when dst_valid[k] = 0.
- dst_prk = new_prk when dst_valid[k] = 1, else 0.
- Map write on rename_fire: for each slot with inst_valid & dst_valid, spec_map[dst_ar] <= new_pr. When several slots write the same AR, the youngest slot wins.
- Commit: each cycle, independent of stall and list_empty, arch_map[commit_ar] <= commit_pr for each valid commit slot. When several slots commit the same AR, the highest index wins.
- Flush: spec_map <= arch_map after this cycle's commit writes (commit bypasses into the restore). out_valid <= 0. The input group is dropped.
- Priority: rst > flush > stall > list_empty > rename.
- Output registers:
  - Load on rename_fire; out_valid <= inst_valid.
  - Hold all values when stall = 1 and flush = 0.
  - out_valid <= 0 when not firing and not stalled (bubble).
- Slots with inst_valid = 0 never write the map. Their output fields are don't-care, but out_valid for those slots is 0.

## Timing
- Latency is 1 cycle from accepted group to registered outputs. Throughput is one group per cycle, back-to-back.
- A map write by group N is visible to group N+1's lookup in the next cycle; no extra bypass is required.
- The commit write at edge t is visible to a flush restore at edge t (same-cycle bypass) and to any later flush.
- Flush takes effect at the next edge. The group presented in the cycle after flush looks up the restored map.
- list_empty is sampled in the same cycle as new_pr*. The free list must not advance its pointer unless rename_fire is high.
- Reset asserted mid-operation restores identity maps at the next edge, regardless of flush, stall, or commit.

## Test plan
- Reset then rename group {dst r1, r2, r3, r4} with new_pr 32..35 and src0 = r1 in all slots. Required: slot0 src0_pr = 1, slot1..3 src0_pr = 32; old_pr = 1, 2, 3, 4; out_valid = 4'b1111 one cycle later.
- Intra-group chain: slot0 dst r5 gets pr 40, slot2 dst r5 gets pr 42, slot3 src1 = r5. Required: slot3 src1_pr = 42, slot2 old_pr = 40. Next group reads r5 as 42.
- stall = 1 for 3 cycles with a valid group. Required: outputs frozen, spec_map unchanged, rename_fire = 0. On release, the group is accepted exactly once.
- list_empty = 1 with a valid group. Required: out_valid = 0 on the next cycle and no map change. When list_empty drops, rename proceeds with the current new_pr values.
- Rename r7 to pr 50, commit r7 to pr 50 in the same cycle as flush, while r8 has only been speculatively renamed to pr 51. Required: after flush r7 maps to 50, r8 maps to 8, and out_valid = 0.
- Assert rst mid-stream after several renames. Required: the next lookup of r0..r31 returns its identity mapping, and out_valid = 0.
